alu_operand_seq: RTL
====================

ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clk samples before a button level is accepted (10 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 switches  input  16  operand value from board switches.
REQ-005 opcode_sw  input  4  operation select from board switches.
REQ-006 btn_load  input  1  raw, asynchronous, bouncing load pushbutton.
REQ-007 btn_clear  input  1  raw, asynchronous, bouncing clear pushbutton.
REQ-008 aluout  input  16  ALU result, combinational from op_a/op_b/opcode.
REQ-009 alu_cout  input  1  ALU carry.
REQ-010 alu_zero  input  1  ALU zero flag.
REQ-011 op_a  output  16  registered operand A to ALU.
REQ-012 op_b  output  16  registered operand B to ALU.
REQ-013 opcode  output  4  registered opcode to ALU.
REQ-014 res  output  16  latched result for display.
REQ-015 res_cout  output  1  latched carry.
REQ-016 res_zero  output  1  latched zero flag.
REQ-017 res_valid  output  1  high while res/res_cout/res_zero hold a valid result.
REQ-018 state  output  2  current FSM state for status LEDs.

Function
REQ-019 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-020 Each debounced level SHALL drive a rising-edge detector producing exactly one 1-cycle pulse per accepted press; a held button SHALL NOT generate further pulses.
REQ-021 FSM states and encoding: LOAD_A=00, LOAD_B=01, EXEC=10, SHOW=11.
REQ-022 LOAD_A + load pulse: op_a <= switches, go LOAD_B.
REQ-023 LOAD_B + load pulse: op_b <= switches, opcode <= opcode_sw, go EXEC.
REQ-024 EXEC: unconditional single cycle; on its closing edge res <= aluout, res_cout <= alu_cout, res_zero <= alu_zero, res_valid <= 1, go SHOW.
REQ-025 Latency: res_valid SHALL rise exactly 2 clk cycles after the cycle in which the LOAD_B load pulse is high.
REQ-026 SHOW + load pulse: res_valid <= 0, go LOAD_A; operands and result registers retain values.
REQ-027 Clear pulse in any state: op_a, op_b, opcode, res, res_cout, res_zero, res_valid <= 0; go LOAD_A.
REQ-028 Clear pulse and load pulse in the same cycle: clear SHALL win; no capture occurs.
REQ-029 Switch changes outside the capture cycles SHALL NOT alter op_a, op_b, opcode or res.
REQ-030 Load pulse during EXEC SHALL be ignored.
REQ-031 Debounce counter SHALL saturate/restart and never wrap into a false acceptance.

Reset
REQ-032 rst high SHALL immediately force state=LOAD_A, all outputs 0, synchronizers, debounce counters, accepted levels and edge detectors to 0, independent of clk.
REQ-033 rst asserted mid-operation (any state) SHALL discard the operation; no pulse SHALL be generated on release even if a button is held at release until it is released and re-pressed.

Structure
REQ-034 Shared package alu_pkg SHALL hold the state encodings, operand width (16) and opcode width (4).
REQ-035 One sub-module btn_debounce (synchronizer + debouncer + edge detector, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4 in bench; bench ALU model = 16-bit adder for opcode 0000)
REQ-036 Press with switches=0x0003, press with switches=0x0005, opcode_sw=0000 -> res=0x0008, res_cout=0, res_zero=0, res_valid=1 exactly 2 cycles after second pulse, state=11.
REQ-037 A=0xFFFF, B=0x0001, opcode 0000 -> res=0x0000, res_cout=1, res_zero=1.
REQ-038 btn_load glitches high for 3 cycles repeatedly, never 4 stable -> no pulse, state stays 00, op_a=0.
REQ-039 btn_load held 50 cycles -> exactly one capture; state advances once.
REQ-040 rst asserted asynchronously while state=01 with op_a=0x1234 -> state=00 and op_a=0 before next clk edge.
REQ-041 In SHOW, btn_clear and btn_load debounced on same cycle -> all outputs 0, state=00, res_valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths and FSM state encodings for the ALU operand
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int OPERAND_W = 16;
  localparam int OPCODE_W  = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Pushbutton conditioner: 2-flop synchronizer, debouncer and
//               rising-edge detector producing one pulse per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q,  prev_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             edge_q,  edge_d;
  logic             armed_q, armed_d;

  // cnt_q holds how many consecutive identical samples have been seen, minus
  // one; it saturates at CNT_LAST so a long stable level can never wrap.
  // Pulses stay disarmed after reset until a stable low is accepted, so a
  // button held through reset release never produces a press.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q;
    edge_d  = level_q;
    if (sync2_q != prev_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      level_d = sync2_q;
      if (!sync2_q) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
      armed_q <= armed_d;
    end
  end

  assign pulse = level_q & ~edge_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/alu_operand_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_seq
// Description : Button-driven sequencer that loads two operands and an opcode
//               into an external ALU and latches its result for display.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_seq
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] switches,
  input  logic [OPCODE_W-1:0]  opcode_sw,
  input  logic                 btn_load,
  input  logic                 btn_clear,
  input  logic [OPERAND_W-1:0] aluout,
  input  logic                 alu_cout,
  input  logic                 alu_zero,
  output logic [OPERAND_W-1:0] op_a,
  output logic [OPERAND_W-1:0] op_b,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [OPERAND_W-1:0] res,
  output logic                 res_cout,
  output logic                 res_zero,
  output logic                 res_valid,
  output logic [1:0]           state
);

  logic load_pulse;
  logic clear_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_load),
    .pulse   (load_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clear),
    .pulse   (clear_pulse)
  );

  state_t               state_q,     state_d;
  logic [OPERAND_W-1:0] op_a_q,      op_a_d;
  logic [OPERAND_W-1:0] op_b_q,      op_b_d;
  logic [OPCODE_W-1:0]  opcode_q,    opcode_d;
  logic [OPERAND_W-1:0] res_q,       res_d;
  logic                 res_cout_q,  res_cout_d;
  logic                 res_zero_q,  res_zero_d;
  logic                 res_valid_q, res_valid_d;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opcode_d    = opcode_q;
    res_d       = res_q;
    res_cout_d  = res_cout_q;
    res_zero_d  = res_zero_q;
    res_valid_d = res_valid_q;
    // Clear outranks any simultaneous load so no capture can slip through.
    if (clear_pulse) begin
      state_d     = LOAD_A;
      op_a_d      = '0;
      op_b_d      = '0;
      opcode_d    = '0;
      res_d       = '0;
      res_cout_d  = 1'b0;
      res_zero_d  = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (load_pulse) begin
            op_a_d  = switches;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (load_pulse) begin
            op_b_d   = switches;
            opcode_d = opcode_sw;
            state_d  = EXEC;
          end
        end
        EXEC: begin
          res_d       = aluout;
          res_cout_d  = alu_cout;
          res_zero_d  = alu_zero;
          res_valid_d = 1'b1;
          state_d     = SHOW;
        end
        SHOW: begin
          if (load_pulse) begin
            res_valid_d = 1'b0;
            state_d     = LOAD_A;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      res_q       <= '0;
      res_cout_q  <= 1'b0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opcode_q    <= opcode_d;
      res_q       <= res_d;
      res_cout_q  <= res_cout_d;
      res_zero_q  <= res_zero_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign opcode    = opcode_q;
  assign res       = res_q;
  assign res_cout  = res_cout_q;
  assign res_zero  = res_zero_q;
  assign res_valid = res_valid_q;
  assign state     = state_q;

endmodule
`default_nettype wire
